sar_adc_seq: RTL and testbench
==============================

# sar_adc_seq

Parametrised successive-approximation ADC sequencer, the next generation of the team's SAR controller. It runs a true MSB-first binary search on an N-bit capacitive DAC and scans CH analog input channels through the front-end mux. It provides single-scan and continuous modes, programmable sample and comparator-settle times, and a start/busy/valid handshake to downstream logic. It sits between the analog front end (track switch, channel mux, DAC, comparator) and the digital result consumer.

## Interface
- N, 8, resolution in bits (≥2)
- CH, 4, number of input channels (≥1)
- SAMPLE_CYC, 2, cycles the track switch is closed (≥1)
- SETTLE, 1, DAC/comparator settle cycles before each compare strobe (≥1)
- CW, $clog2(CH) (min 1), channel index width (derived localparam)

Ports:
- clk_1Mhz  in  1  sole clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  begin a scan; sampled only in IDLE
- continuous  in  1  1 = rescan indefinitely, 0 = stop after channel CH-1
- decision  in  1  comparator output, 1 = Vin ≥ Vdac
- sample  out  1  track switch enable
- comp_clk  out  1  comparator strobe
- dac_code  out  N  current trial code to the DAC
- ch_sel  out  CW  analog mux select
- busy  out  1  high from leaving IDLE until return to IDLE
- result_valid  out  1  one-cycle pulse, result/result_ch valid
- result  out  N  converted code
- result_ch  out  CW  channel of result

## Operation
- Reset values: sample 0, comp_clk 0, dac_code 0, ch_sel 0, busy 0, result_valid 0, result 0, result_ch 0, state IDLE, bit index N-1.
- States and transitions:
  - IDLE
    - start=1 → SAMPLE with ch_sel=0 and busy=1.
    - start asserted in any other state is ignored.
  - SAMPLE
    - sample=1 and dac_code = 1<<(N-1) for SAMPLE_CYC cycles, then → SETTLE.
  - SETTLE
    - sample=0, comp_clk=0, held for SETTLE cycles, then → COMPARE.
  - COMPARE
    - comp_clk=1 for one cycle. decision is captured on the edge that ends this cycle.
    - On that edge: dac_code[i] = decision; if i>0, dac_code[i-1] = 1 and i decrements, → SETTLE.
    - If i=0 → DONE.
  - DONE
    - result_valid=1, result=dac_code, result_ch=ch_sel for one cycle; bit index reloads to N-1.
    - If ch_sel=CH-1 and continuous=0 → IDLE with busy=0.
    - Otherwise ch_sel advances, wrapping CH-1→0, → SAMPLE.
- continuous is sampled only in DONE. Deasserting it mid-scan completes the scan through channel CH-1.
- result/result_ch hold their values until the next DONE.
- Reset asserted mid-conversion aborts immediately; no partial result is produced.
- CH=1: ch_sel stays 0 and result_ch stays 0.

## Timing
- start high in IDLE at edge k → SAMPLE and busy=1 from cycle k+1.
- Per-conversion length T = SAMPLE_CYC + N·(SETTLE+1) + 1 cycles, from SAMPLE entry through the DONE cycle.
- Back-to-back conversions have no gap: SAMPLE follows DONE directly.
- A full single scan occupies CH·T cycles of busy.
- comp_clk is high for exactly N single cycles per conversion. It is never high while sample=1.
- decision must be stable during the COMPARE cycle. It is not registered elsewhere.
- All outputs are registered (glitch-free to the analog side).

## Structure
- Package sar_adc_pkg holds:
  - state encoding localparams IDLE, SAMPLE, SETTLE, COMPARE, DONE (3 bits);
  - the default parameter values.
- Sub-module sar_bit_reg(N) owns dac_code and the bit index.
  - Inputs: load_mid (set code to midscale, index N-1) and step (apply decision, advance one bit).
  - Output: last_bit (index=0).
- The top level holds the FSM, the sample/settle down-counter (width covering max(SAMPLE_CYC, SETTLE)), the channel counter and the result registers.

## Test plan
All scenarios use N=4, CH=2, SAMPLE_CYC=1, SETTLE=1, so T=10. The comparator model is decision = (vin[ch_sel] ≥ dac_code).
- Binary search: vin0=11, start pulse.
  - dac_code trials are 8, 12, 10, 11.
  - result=4'hB, result_ch=0 at result_valid, 10 cycles after SAMPLE entry.
- Single scan: vin0=0, vin1=15, continuous=0.
  - Two result_valid pulses: (0, ch0) and then (15, ch1), 10 cycles apart.
  - busy drops the cycle after the second DONE and stays low.
- Continuous mode: continuous=1 for three conversions, then deasserted.
  - ch_sel sequence is 0, 1, 0, 1.
  - The scan stops after channel 1 completes, giving exactly 4 results.
- Start while busy: pulse start mid-conversion.
  - No restart occurs; timing and results are identical to the unperturbed run.
- Async reset: assert reset in the second COMPARE of a conversion.
  - All outputs go to reset values without waiting for a clock edge; no result_valid is produced.
  - A start after release yields a correct conversion.
- Strobe checks:
  - comp_clk is never high while sample=1.
  - Exactly 4 strobes per conversion.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared state encoding and default parameters for the SAR ADC sequencer
package sar_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_N          = 8;
    localparam int DEF_CH         = 4;
    localparam int DEF_SAMPLE_CYC = 2;
    localparam int DEF_SETTLE     = 1;

endpackage

// File: rtl/sar_bit_reg.sv
// rtl/sar_bit_reg.sv - successive-approximation trial code register and bit pointer
module sar_bit_reg #(
    parameter int N = 8
) (
    input  logic         clk_1Mhz,
    input  logic         reset,
    input  logic         load_mid,
    input  logic         step,
    input  logic         decision,
    output logic [N-1:0] dac_code,
    output logic         last_bit
);

    localparam int            IW      = $clog2(N);
    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);
    localparam logic [N-1:0]  MID     = {1'b1, {(N-1){1'b0}}};

    logic [IW-1:0] idx;

    // After the LSB decision the pointer rewinds so the next conversion starts at the MSB.
    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            dac_code <= '0;
            idx      <= TOP_IDX;
        end else if (load_mid) begin
            dac_code <= MID;
            idx      <= TOP_IDX;
        end else if (step) begin
            dac_code[idx] <= decision;
            if (idx != '0) begin
                dac_code[idx - 1'b1] <= 1'b1;
                idx                  <= idx - 1'b1;
            end else begin
                idx <= TOP_IDX;
            end
        end
    end

    assign last_bit = (idx == '0);

endmodule

// File: rtl/sar_adc_seq.sv
// rtl/sar_adc_seq.sv - multi-channel SAR ADC sequencer with single-scan and continuous modes
module sar_adc_seq
    import sar_adc_pkg::*;
#(
    parameter int  N          = DEF_N,
    parameter int  CH         = DEF_CH,
    parameter int  SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int  SETTLE     = DEF_SETTLE,
    localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk_1Mhz,
    input  logic          reset,
    input  logic          start,
    input  logic          continuous,
    input  logic          decision,
    output logic          sample,
    output logic          comp_clk,
    output logic [N-1:0]  dac_code,
    output logic [CW-1:0] ch_sel,
    output logic          busy,
    output logic          result_valid,
    output logic [N-1:0]  result,
    output logic [CW-1:0] result_ch
);

    localparam int            CNT_MAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
    localparam int            CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             scan_end;
    logic             load_mid;
    logic             step;
    logic             last_bit;
    logic [CW-1:0]    ch_next;

    assign scan_end = (ch_sel == CH_LAST) && !continuous;
    assign ch_next  = (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
    assign load_mid = ((state == ST_IDLE) && start) || ((state == ST_DONE) && !scan_end);
    assign step     = (state == ST_COMPARE);

    sar_bit_reg #(.N(N)) u_bit_reg (
        .clk_1Mhz (clk_1Mhz),
        .reset    (reset),
        .load_mid (load_mid),
        .step     (step),
        .decision (decision),
        .dac_code (dac_code),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sample       <= 1'b0;
            comp_clk     <= 1'b0;
            ch_sel       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
        end else begin
            comp_clk     <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SAMPLE;
                        sample <= 1'b1;
                        busy   <= 1'b1;
                        ch_sel <= '0;
                        cnt    <= SAMPLE_LOAD;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == '0) begin
                        state  <= ST_SETTLE;
                        sample <= 1'b0;
                        cnt    <= SETTLE_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state    <= ST_COMPARE;
                        comp_clk <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_COMPARE: begin
                    // The LSB decision lands in the code register on this same edge, so fold it in here.
                    if (last_bit) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        result       <= {dac_code[N-1:1], decision};
                        result_ch    <= ch_sel;
                    end else begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                ST_DONE: begin
                    if (scan_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state  <= ST_SAMPLE;
                        sample <= 1'b1;
                        ch_sel <= ch_next;
                        cnt    <= SAMPLE_LOAD;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    sample <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb/tb_sar_adc_seq.sv - scoreboard bench for sar_adc_seq with N=4, CH=2, SAMPLE_CYC=1, SETTLE=1
module tb_sar_adc_seq;

    typedef struct packed {
        logic [3:0] code;
        logic       ch;
    } exp_t;

    logic       clk_1Mhz = 1'b0;
    logic       reset;
    logic       start;
    logic       continuous;
    logic       decision;
    logic       sample;
    logic       comp_clk;
    logic [3:0] dac_code;
    logic       ch_sel;
    logic       busy;
    logic       result_valid;
    logic [3:0] result;
    logic       result_ch;

    logic [3:0] vin [2];
    exp_t       exp_q [$];
    logic [3:0] trials [$];
    int         errors = 0;
    int         checks = 0;
    int         strobes = 0;
    int         busy_cycles = 0;
    int         w;
    int         seen;

    always #5 clk_1Mhz = ~clk_1Mhz;

    assign decision = (vin[ch_sel] >= dac_code);

    sar_adc_seq #(.N(4), .CH(2), .SAMPLE_CYC(1), .SETTLE(1)) dut (
        .clk_1Mhz     (clk_1Mhz),
        .reset        (reset),
        .start        (start),
        .continuous   (continuous),
        .decision     (decision),
        .sample       (sample),
        .comp_clk     (comp_clk),
        .dac_code     (dac_code),
        .ch_sel       (ch_sel),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_ch    (result_ch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_scan(input logic [3:0] a, input logic [3:0] b);
        exp_q.push_back('{code: a, ch: 1'b0});
        exp_q.push_back('{code: b, ch: 1'b1});
    endtask

    // Counts negedges until result_valid; optionally re-pulses start at negedge poke_at.
    task automatic wait_valid(input int budget, input int poke_at, output int waited);
        waited = 0;
        trials.delete();
        do begin
            @(negedge clk_1Mhz);
            waited++;
            start = (waited == poke_at);
            if (comp_clk) trials.push_back(dac_code);
        end while (!result_valid && waited < budget);
        start = 1'b0;
        check("valid_seen", result_valid, 1);
    endtask

    task automatic check_trials(input logic [3:0] e0, input logic [3:0] e1,
                                input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] e [4];
        e = '{e0, e1, e2, e3};
        check("trial_count", trials.size(), 4);
        if (trials.size() == 4)
            for (int i = 0; i < 4; i++) check("trial_code", trials[i], e[i]);
    endtask

    task automatic check_reset_values();
        check("rst_sample", sample, 0);
        check("rst_comp_clk", comp_clk, 0);
        check("rst_dac_code", dac_code, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_result_ch", result_ch, 0);
    endtask

    task automatic single_scan(input logic [3:0] a, input logic [3:0] b, input int poke0, input int poke1);
        vin[0] = a;
        vin[1] = b;
        push_scan(a, b);
        @(negedge clk_1Mhz);
        busy_cycles = 0;
        start = 1'b1;
        wait_valid(30, poke0, w);
        check("latency_ch0", w, 10);
        wait_valid(30, poke1, w);
        check("gap_ch1", w, 10);
        @(negedge clk_1Mhz);
        check("busy_drop", busy, 0);
        check("busy_len", busy_cycles, 20);
    endtask

    always @(negedge clk_1Mhz) begin
        if (reset) begin
            strobes = 0;
        end else begin
            if (busy) busy_cycles++;
            if (comp_clk) begin
                strobes++;
                check("no_sample_on_strobe", sample, 0);
            end
            if (result_valid) begin
                check("strobes_per_conv", strobes, 4);
                strobes = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", result_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.code);
                    check("result_ch", result_ch, e.ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        vin[0]     = 4'd0;
        vin[1]     = 4'd0;
        repeat (2) @(negedge clk_1Mhz);
        check_reset_values();
        reset = 1'b0;

        // Binary search trials on both channels of a single scan.
        vin[0] = 4'd11;
        vin[1] = 4'd5;
        push_scan(4'd11, 4'd5);
        @(negedge clk_1Mhz);
        busy_cycles = 0;
        start = 1'b1;
        wait_valid(30, -1, w);
        check("latency_first", w, 10);
        check_trials(4'd8, 4'd12, 4'd10, 4'd11);
        wait_valid(30, -1, w);
        check("gap_first", w, 10);
        check_trials(4'd8, 4'd4, 4'd6, 4'd5);
        @(negedge clk_1Mhz);
        check("busy_drop_first", busy, 0);
        check("busy_len_first", busy_cycles, 20);
        repeat (15) @(negedge clk_1Mhz);
        check("busy_stays_low", busy, 0);

        // Full-scale endpoints.
        single_scan(4'd0, 4'd15, -1, -1);
        repeat (3) @(negedge clk_1Mhz);

        // Continuous mode: release after the third result, scan ends after channel 1.
        vin[0] = 4'd3;
        vin[1] = 4'd9;
        push_scan(4'd3, 4'd9);
        push_scan(4'd3, 4'd9);
        continuous = 1'b1;
        @(negedge clk_1Mhz);
        start = 1'b1;
        wait_valid(30, -1, w);
        check("cont_lat", w, 10);
        for (int k = 0; k < 2; k++) begin
            wait_valid(30, -1, w);
            check("cont_gap", w, 10);
        end
        continuous = 1'b0;
        wait_valid(30, -1, w);
        check("cont_gap_last", w, 10);
        @(negedge clk_1Mhz);
        check("cont_busy_drop", busy, 0);
        repeat (25) @(negedge clk_1Mhz);
        check("cont_stopped", busy, 0);

        // start pulses mid-conversion must be ignored.
        single_scan(4'd11, 4'd5, 4, 1);
        check_trials(4'd8, 4'd4, 4'd6, 4'd5);
        repeat (15) @(negedge clk_1Mhz);
        check("poke_no_restart", busy, 0);

        // Asynchronous reset during the second compare strobe.
        vin[0] = 4'd11;
        vin[1] = 4'd5;
        @(negedge clk_1Mhz);
        start = 1'b1;
        @(negedge clk_1Mhz);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk_1Mhz);
            if (comp_clk) seen++;
        end
        check("reached_compare2", seen, 2);
        reset = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk_1Mhz);
        reset = 1'b0;
        repeat (5) @(negedge clk_1Mhz);
        check("abort_idle", busy, 0);
        check("abort_no_result", exp_q.size(), 0);

        single_scan(4'd11, 4'd5, -1, -1);
        check_trials(4'd8, 4'd4, 4'd6, 4'd5);

        repeat (5) @(negedge clk_1Mhz);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
